branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/branch_cmp.sv | 34 +++
 rtl/branch_unit.sv | 134 +++++++++++++
 tb/tb_branch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-flow opcodes, branch-unit state encoding
// and the fixed instruction size.
package pipe_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd2,
    OP_BGE  = 3'd3,
    OP_BLTU = 3'd4,
    OP_BGEU = 3'd5,
    OP_JAL  = 3'd6,
    OP_JALR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SHADOW   = 2'd2
  } state_e;

  localparam logic [63:0] INSN_SIZE = 64'd8;

  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[2:0] != 3'b000;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; jumps are unconditionally taken.
module branch_cmp
  import pipe_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [63:0] rs1_val,
  input  logic [63:0] rs2_val,
  output logic        taken
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (rs1_val == rs2_val);
  assign w_lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign w_lt_u = (rs1_val < rs2_val);

  always_comb begin
    taken = 1'b0;
    case (op_e'(op))
      OP_BEQ:  taken = w_eq;
      OP_BNE:  taken = !w_eq;
      OP_BLT:  taken = w_lt_s;
      OP_BGE:  taken = !w_lt_s;
      OP_BLTU: taken = w_lt_u;
      OP_BGEU: taken = !w_lt_u;
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates control-flow instructions, redirects the PC
// stage, squashes SHADOW wrong-path fetch cycles and keeps saturating statistics.
module branch_unit
  import pipe_pkg::*;
#(
  parameter int unsigned SHADOW = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [2:0]       op,
  input  logic [63:0]      pc_in,
  input  logic [63:0]      rs1_val,
  input  logic [63:0]      rs2_val,
  input  logic [63:0]      imm,
  output logic             mux_ctrl,
  output logic [63:0]      branch_addr,
  output logic             flush,
  output logic [63:0]      link_addr,
  output logic             addr_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Value loaded on SHADOW entry: remaining squash cycles after the current one.
  localparam logic [2:0] SHADOW_LAST = (SHADOW > 1) ? 3'(SHADOW - 2) : 3'd0;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [2:0]       r_shadow_cnt;
  logic [2:0]       w_shadow_cnt_nxt;
  logic [63:0]      r_branch_addr;
  logic [63:0]      r_link_addr;
  logic             r_addr_err;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_taken;
  logic [63:0]      w_target;
  logic             w_misalign;
  logic             w_accept;
  logic             w_redirect;

  branch_cmp u_cmp (
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .taken   (w_taken)
  );

  always_comb begin
    w_target = pc_in + imm;
    if (op_e'(op) == OP_JALR) begin
      w_target = (rs1_val + imm) & ~64'h7;
    end
  end

  assign w_misalign = is_misaligned(w_target);
  assign w_accept   = valid_in && (r_state == ST_IDLE);
  assign w_redirect = w_accept && w_taken && !w_misalign;

  always_comb begin
    w_state_nxt      = r_state;
    w_shadow_cnt_nxt = r_shadow_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_redirect) begin
          w_state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (SHADOW > 1) begin
          w_state_nxt      = ST_SHADOW;
          w_shadow_cnt_nxt = SHADOW_LAST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHADOW: begin
        if (r_shadow_cnt == 3'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_shadow_cnt_nxt = r_shadow_cnt - 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shadow_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow_cnt <= w_shadow_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_addr <= '0;
      r_link_addr   <= '0;
      r_addr_err    <= 1'b0;
      r_br_cnt      <= '0;
      r_taken_cnt   <= '0;
    end else begin
      r_addr_err <= w_accept && w_taken && w_misalign;
      if (w_redirect) begin
        r_branch_addr <= w_target;
      end
      if (w_accept) begin
        r_link_addr <= pc_in + INSN_SIZE;
      end
      if (w_accept && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_redirect && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  // Decoded from the state register so an asynchronous reset drops both at once.
  assign mux_ctrl    = (r_state == ST_REDIRECT);
  assign flush       = (r_state != ST_IDLE);
  assign branch_addr = r_branch_addr;
  assign link_addr   = r_link_addr;
  assign addr_err    = r_addr_err;
  assign br_cnt      = r_br_cnt;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized traffic
// compared against a cycle-countdown reference model.
module tb_branch_unit;
  import pipe_pkg::*;

  localparam int unsigned SHADOW  = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [2:0]       op;
  logic [63:0]      pc_in;
  logic [63:0]      rs1_val;
  logic [63:0]      rs2_val;
  logic [63:0]      imm;
  logic             mux_ctrl;
  logic [63:0]      branch_addr;
  logic             flush;
  logic [63:0]      link_addr;
  logic             addr_err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  int          m_flush_left;
  logic        m_mux;
  logic        m_addr_err;
  logic [63:0] m_baddr;
  logic [63:0] m_link;
  int          m_br;
  int          m_tk;

  branch_unit #(.SHADOW(SHADOW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .op          (op),
    .pc_in       (pc_in),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .imm         (imm),
    .mux_ctrl    (mux_ctrl),
    .branch_addr (branch_addr),
    .flush       (flush),
    .link_addr   (link_addr),
    .addr_err    (addr_err),
    .br_cnt      (br_cnt),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    longint sa = a;
    longint sb = b;
    case (o)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa < sb;
      3'd3:    return sa >= sb;
      3'd4:    return a < b;
      3'd5:    return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] sat(input int c);
    return (c > CNT_MAX) ? 64'(CNT_MAX) : 64'(c);
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_mux        = 1'b0;
    m_addr_err   = 1'b0;
    m_baddr      = '0;
    m_link       = '0;
    m_br         = 0;
    m_tk         = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [63:0] tgt;
    m_mux      = 1'b0;
    m_addr_err = 1'b0;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (valid_in) begin
      m_br++;
      m_link = pc_in + 64'd8;
      tgt = (op == 3'd7) ? ((rs1_val + imm) / 8) * 8 : pc_in + imm;
      if (ref_taken(op, rs1_val, rs2_val)) begin
        if (tgt % 8 != 0) begin
          m_addr_err = 1'b1;
        end else begin
          m_mux        = 1'b1;
          m_baddr      = tgt;
          m_flush_left = SHADOW;
          m_tk++;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("mux_ctrl", 64'(mux_ctrl), 64'(m_mux));
    chk("flush", 64'(flush), 64'(m_flush_left > 0));
    chk("branch_addr", branch_addr, m_baddr);
    chk("link_addr", link_addr, m_link);
    chk("addr_err", 64'(addr_err), 64'(m_addr_err));
    chk("br_cnt", 64'(br_cnt), sat(m_br));
    chk("taken_cnt", 64'(taken_cnt), sat(m_tk));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [63:0] pc,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] im);
    valid_in = v;
    op       = o;
    pc_in    = pc;
    rs1_val  = a;
    rs2_val  = b;
    imm      = im;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [63:0] r_a;
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    #2 rst = 1'b0;

    // BEQ taken: redirect to 0x140, two flush cycles
    drive(1'b1, OP_BEQ, 64'h100, 64'd5, 64'd5, 64'h40);
    step();
    chk("beq_mux", 64'(mux_ctrl), 64'd1);
    chk("beq_addr", branch_addr, 64'h140);
    chk("beq_flush1", 64'(flush), 64'd1);
    chk("beq_taken_cnt", 64'(taken_cnt), 64'd1);
    idle();
    step();
    chk("beq_flush2", 64'(flush), 64'd1);
    chk("beq_mux_drop", 64'(mux_ctrl), 64'd0);
    chk("beq_addr_hold", branch_addr, 64'h140);
    step();
    chk("beq_flush_end", 64'(flush), 64'd0);

    // BLT vs BLTU with -1 vs 1
    drive(1'b1, OP_BLT, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20);
    step();
    chk("blt_mux", 64'(mux_ctrl), 64'd1);
    idle();
    step();
    step();
    drive(1'b1, OP_BLTU, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20);
    step();
    chk("bltu_mux", 64'(mux_ctrl), 64'd0);
    chk("bltu_flush", 64'(flush), 64'd0);
    idle();
    step();

    // JALR target alignment and link address
    drive(1'b1, OP_JALR, 64'h200, 64'h1003, 64'd0, 64'h10);
    step();
    chk("jalr_addr", branch_addr, 64'h1010);
    chk("jalr_link", link_addr, 64'h208);
    idle();
    step();
    step();

    // Misaligned BNE
    drive(1'b1, OP_BNE, 64'h100, 64'd1, 64'd2, 64'h4);
    step();
    chk("mis_err", 64'(addr_err), 64'd1);
    chk("mis_mux", 64'(mux_ctrl), 64'd0);
    chk("mis_br_cnt", 64'(br_cnt), 64'd5);
    chk("mis_taken_cnt", 64'(taken_cnt), 64'd3);
    idle();
    step();
    chk("mis_err_pulse", 64'(addr_err), 64'd0);

    // Valid during REDIRECT and SHADOW is ignored
    drive(1'b1, OP_BEQ, 64'h500, 64'd7, 64'd7, 64'h80);
    step();
    drive(1'b1, OP_JAL, 64'h800, 64'd0, 64'd0, 64'h8);
    step();
    step();
    idle();
    step();
    chk("ign_mux", 64'(mux_ctrl), 64'd0);
    chk("ign_addr", branch_addr, 64'h580);
    chk("ign_br_cnt", 64'(br_cnt), 64'd6);
    chk("ign_taken_cnt", 64'(taken_cnt), 64'd4);

    // Asynchronous reset in the redirect cycle
    drive(1'b1, OP_BEQ, 64'h100, 64'd5, 64'd5, 64'h40);
    step();
    chk("rst_pre_mux", 64'(mux_ctrl), 64'd1);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_mux", 64'(mux_ctrl), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_br_cnt", 64'(br_cnt), 64'd0);
    chk("rst_taken_cnt", 64'(taken_cnt), 64'd0);
    chk("rst_addr", branch_addr, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    #2 rst = 1'b0;

    // First edge after reset release accepts
    drive(1'b1, OP_JAL, 64'h400, 64'd0, 64'd0, 64'h40);
    step();
    chk("post_rst_mux", 64'(mux_ctrl), 64'd1);
    chk("post_rst_addr", branch_addr, 64'h440);
    chk("post_rst_br_cnt", 64'(br_cnt), 64'd1);
    idle();
    step();
    step();

    // Randomized traffic; counters saturate at CNT_MAX
    for (int i = 0; i < 3000; i++) begin
      r_a = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)),
            {$urandom, $urandom} & ~64'h7,
            r_a,
            ($urandom_range(0, 2) == 0) ? r_a
              : (($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom}),
            ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
              : ({$urandom, $urandom} & ~64'h7));
      step();
    end
    chk("sat_br_cnt", 64'(br_cnt), 64'd15);
    chk("sat_taken_cnt", 64'(taken_cnt), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
